// File: rtl/tlb_op_seq.sv
// TLB maintenance sequencer: accepts one committed TLB op at a time from WB,
// drives the TLB array's single-cycle access ports, expands invtlb into a
// full-array scan and supplies the tlbfill replacement index.
module tlb_op_seq #(
    parameter int TLBNUM = 32,
    parameter int IDX_W  = $clog2(TLBNUM)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [4:0]       req_op,
    input  logic [4:0]       req_inv_op,
    input  logic [9:0]       req_asid,
    input  logic [18:0]      req_vpn,
    input  logic [IDX_W-1:0] req_index,
    output logic             tlb_we,
    output logic [IDX_W-1:0] tlb_w_index,
    output logic             tlb_re,
    output logic             tlb_s_en,
    output logic [IDX_W-1:0] tlb_r_index,
    input  logic             srch_found,
    input  logic [IDX_W-1:0] srch_index,
    output logic             inv_check_en,
    output logic [IDX_W-1:0] inv_index,
    output logic [4:0]       inv_op,
    output logic [9:0]       inv_asid,
    output logic [18:0]      inv_vpn,
    input  logic             inv_hit,
    output logic             tlb_clr_en,
    output logic             done_valid,
    output logic             resp_found,
    output logic [IDX_W-1:0] resp_index,
    output logic             busy
);

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_SCAN, S_DONE} state_t;
    typedef enum logic [2:0] {K_NONE, K_INV, K_WR, K_FILL, K_RD, K_SRCH} kind_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TLBNUM - 1);

    state_t           state, state_nxt;
    kind_t            kind_q;
    kind_t            req_kind;
    logic             accept;
    logic [IDX_W-1:0] fill_ptr;
    logic [IDX_W-1:0] fill_idx_q;
    logic [IDX_W-1:0] scan_idx;
    logic [IDX_W-1:0] idx_q;
    logic [4:0]       inv_op_q;
    logic [9:0]       asid_q;
    logic [18:0]      vpn_q;

    // Priority resolution of a possibly multi-hot op field.
    function automatic kind_t resolve_op(input logic [4:0] op);
        if (op[0])      return K_INV;
        else if (op[1]) return K_WR;
        else if (op[3]) return K_FILL;
        else if (op[2]) return K_RD;
        else if (op[4]) return K_SRCH;
        else            return K_NONE;
    endfunction

    assign req_kind = resolve_op(req_op);
    assign accept   = req_valid && (state == S_IDLE);

    assign inv_op   = inv_op_q;
    assign inv_asid = asid_q;
    assign inv_vpn  = vpn_q;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    // Free-running replacement pointer; wraps naturally at TLBNUM.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) fill_ptr <= '0;
        else       fill_ptr <= fill_ptr + 1'b1;
    end

    // Capture the resolved op and all operands on acceptance.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            kind_q     <= K_NONE;
            fill_idx_q <= '0;
            idx_q      <= '0;
            inv_op_q   <= '0;
            asid_q     <= '0;
            vpn_q      <= '0;
        end else if (accept) begin
            kind_q     <= req_kind;
            fill_idx_q <= fill_ptr;
            idx_q      <= req_index;
            inv_op_q   <= req_inv_op;
            asid_q     <= req_asid;
            vpn_q      <= req_vpn;
        end
    end

    // Scan index: restarts at 0 for each invtlb and stops at the last entry.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scan_idx <= '0;
        end else if (accept && req_kind == K_INV) begin
            scan_idx <= '0;
        end else if (state == S_SCAN && scan_idx != LAST_IDX) begin
            scan_idx <= scan_idx + 1'b1;
        end
    end

    // Next-state and output decode from registered state.
    always_comb begin
        state_nxt    = state;
        req_ready    = 1'b0;
        busy         = 1'b1;
        tlb_we       = 1'b0;
        tlb_w_index  = '0;
        tlb_re       = 1'b0;
        tlb_r_index  = '0;
        tlb_s_en     = 1'b0;
        inv_check_en = 1'b0;
        inv_index    = '0;
        tlb_clr_en   = 1'b0;
        done_valid   = 1'b0;
        resp_found   = 1'b0;
        resp_index   = '0;
        case (state)
            S_IDLE: begin
                req_ready = 1'b1;
                busy      = 1'b0;
                if (req_valid) begin
                    state_nxt = (req_kind == K_INV) ? S_SCAN : S_ACCESS;
                end
            end
            S_ACCESS: begin
                case (kind_q)
                    K_WR: begin
                        tlb_we      = 1'b1;
                        tlb_w_index = idx_q;
                    end
                    K_FILL: begin
                        tlb_we      = 1'b1;
                        tlb_w_index = fill_idx_q;
                    end
                    K_RD: begin
                        tlb_re      = 1'b1;
                        tlb_r_index = idx_q;
                    end
                    K_SRCH:  tlb_s_en = 1'b1;
                    default: ;
                endcase
                state_nxt = S_DONE;
            end
            S_SCAN: begin
                inv_check_en = 1'b1;
                inv_index    = scan_idx;
                // ops 0/1 clear everything, 2..6 clear on match, >6 clear nothing
                tlb_clr_en   = (inv_op_q <= 5'd1) ||
                               ((inv_op_q >= 5'd2) && (inv_op_q <= 5'd6) && inv_hit);
                if (scan_idx == LAST_IDX) state_nxt = S_DONE;
            end
            S_DONE: begin
                done_valid = 1'b1;
                if (kind_q == K_SRCH) begin
                    resp_found = srch_found;
                    resp_index = srch_index;
                end
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_tlb_op_seq.sv
// Self-checking bench for tlb_op_seq: directed scenarios from the test plan
// plus randomized back-to-back ops against a behavioural model.
module tb_tlb_op_seq;

    localparam int K_NONE = 0, K_INV = 1, K_WR = 2, K_FILL = 3, K_RD = 4, K_SRCH = 5;

    logic        clk, reset;
    logic        req_valid, req_ready;
    logic [4:0]  req_op, req_inv_op;
    logic [9:0]  req_asid;
    logic [18:0] req_vpn;
    logic [4:0]  req_index;
    logic        tlb_we, tlb_re, tlb_s_en;
    logic [4:0]  tlb_w_index, tlb_r_index;
    logic        srch_found;
    logic [4:0]  srch_index;
    logic        inv_check_en;
    logic [4:0]  inv_index, inv_op;
    logic [9:0]  inv_asid;
    logic [18:0] inv_vpn;
    logic        inv_hit, tlb_clr_en, done_valid, resp_found, busy;
    logic [4:0]  resp_index;

    int n_cmp = 0;
    int n_err = 0;
    int edges;

    tlb_op_seq #(.TLBNUM(32)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_inv_op(req_inv_op), .req_asid(req_asid), .req_vpn(req_vpn),
        .req_index(req_index),
        .tlb_we(tlb_we), .tlb_w_index(tlb_w_index), .tlb_re(tlb_re),
        .tlb_s_en(tlb_s_en), .tlb_r_index(tlb_r_index),
        .srch_found(srch_found), .srch_index(srch_index),
        .inv_check_en(inv_check_en), .inv_index(inv_index),
        .inv_op(inv_op), .inv_asid(inv_asid), .inv_vpn(inv_vpn),
        .inv_hit(inv_hit), .tlb_clr_en(tlb_clr_en),
        .done_valid(done_valid), .resp_found(resp_found), .resp_index(resp_index),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Clock edges since reset release; equals the expected fill pointer mod 32.
    always @(posedge clk or posedge reset) begin
        if (reset) edges <= 0;
        else       edges <= edges + 1;
    end

    logic [28:0] obs;
    assign obs = {req_ready, busy, tlb_we, tlb_w_index, tlb_re, tlb_r_index, tlb_s_en,
                  inv_check_en, inv_index, tlb_clr_en, done_valid, resp_found, resp_index};

    function automatic logic [28:0] pack_exp(
        input logic rdy, input logic bsy, input logic we, input logic [4:0] widx,
        input logic re, input logic [4:0] ridx, input logic sen, input logic ice,
        input logic [4:0] iidx, input logic clr, input logic dv, input logic rf,
        input logic [4:0] ri);
        return {rdy, bsy, we, widx, re, ridx, sen, ice, iidx, clr, dv, rf, ri};
    endfunction

    function automatic logic [28:0] idle_vec();
        return pack_exp(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endfunction

    function automatic int op_kind(input logic [4:0] op);
        if (op[0]) return K_INV;
        if (op[1]) return K_WR;
        if (op[3]) return K_FILL;
        if (op[2]) return K_RD;
        if (op[4]) return K_SRCH;
        return K_NONE;
    endfunction

    function automatic logic clr_rule(input logic [4:0] iop, input logic hit);
        if (iop == 0 || iop == 1) return 1'b1;
        if (iop >= 2 && iop <= 6) return hit;
        return 1'b0;
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        req_valid = 0; inv_hit = 0; srch_found = 0; srch_index = 0;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    // Issue one op and follow it cycle by cycle until the sequencer is idle again.
    task automatic run_op(input string name, input logic [4:0] op, input logic [4:0] iop,
                          input logic [9:0] asid, input logic [18:0] vpn,
                          input logic [4:0] idx, input logic [31:0] hits,
                          input logic sf, input logic [4:0] si);
        int kind, fill_exp, waited;
        logic [28:0] e;
        logic [4:0] widx;
        waited = 0;
        while (req_ready !== 1'b1 && waited < 50) begin
            @(posedge clk); #1;
            waited++;
        end
        n_cmp++;
        if (obs !== idle_vec()) begin
            n_err++;
            $display("FAIL %s pre_accept_idle: got %h required %h", name, obs, idle_vec());
            return;
        end
        kind     = op_kind(op);
        fill_exp = edges % 32;
        req_valid = 1; req_op = op; req_inv_op = iop; req_asid = asid;
        req_vpn = vpn; req_index = idx;
        @(posedge clk); #1;
        // junk on the request bus while busy must be ignored
        req_op = 5'($urandom); req_inv_op = 5'($urandom); req_asid = 10'($urandom);
        req_vpn = 19'($urandom); req_index = 5'($urandom);
        srch_found = 1'($urandom); srch_index = 5'($urandom);
        if (kind == K_INV) begin
            for (int k = 0; k < 32; k++) begin
                inv_hit = hits[k];
                #1;
                e = pack_exp(0, 1, 0, 0, 0, 0, 0, 1, 5'(k), clr_rule(iop, hits[k]), 0, 0, 0);
                n_cmp++;
                if (obs !== e || {inv_op, inv_asid, inv_vpn} !== {iop, asid, vpn}) begin
                    n_err++;
                    $display("FAIL %s scan%0d: got %h args %h required %h args %h",
                             name, k, obs, {inv_op, inv_asid, inv_vpn}, e, {iop, asid, vpn});
                end
                @(posedge clk); #1;
            end
            inv_hit = 0;
        end else begin
            widx = (kind == K_WR) ? idx : (kind == K_FILL) ? 5'(fill_exp) : 5'd0;
            e = pack_exp(0, 1, kind == K_WR || kind == K_FILL, widx,
                         kind == K_RD, (kind == K_RD) ? idx : 5'd0, kind == K_SRCH,
                         0, 0, 0, 0, 0, 0);
            n_cmp++;
            if (obs !== e) begin
                n_err++;
                $display("FAIL %s access: got %h required %h", name, obs, e);
            end
            @(posedge clk); #1;
        end
        srch_found = sf; srch_index = si;
        #1;
        e = pack_exp(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1,
                     (kind == K_SRCH) ? sf : 1'b0, (kind == K_SRCH) ? si : 5'd0);
        n_cmp++;
        if (obs !== e || {inv_op, inv_asid, inv_vpn} !== {iop, asid, vpn}) begin
            n_err++;
            $display("FAIL %s done: got %h args %h required %h args %h",
                     name, obs, {inv_op, inv_asid, inv_vpn}, e, {iop, asid, vpn});
        end
        req_valid = 0;
        @(posedge clk); #1;
        srch_found = 1'($urandom); srch_index = 5'($urandom);
        #1;
        n_cmp++;
        if (obs !== idle_vec()) begin
            n_err++;
            $display("FAIL %s back_idle: got %h required %h", name, obs, idle_vec());
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        req_valid = 0; inv_hit = 0; srch_found = 1; srch_index = 5'd9;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if (obs !== idle_vec() || {inv_op, inv_asid, inv_vpn} !== 34'd0) begin
            n_err++;
            $display("FAIL reset_state: got %h args %h required %h args 0",
                     obs, {inv_op, inv_asid, inv_vpn}, idle_vec());
        end
        reset = 1'b0; srch_found = 0; srch_index = 0;
        @(posedge clk); #1;
        n_cmp++;
        if (obs !== idle_vec()) begin
            n_err++;
            $display("FAIL reset_release: got %h required %h", obs, idle_vec());
        end
    endtask

    task automatic test_tlbwr();
        run_op("tlbwr7", 5'b00010, 5'd3, 10'h155, 19'h2_3456, 5'd7, 32'h0, 0, 0);
    endtask

    task automatic test_tlbsrch();
        run_op("tlbsrch_hit", 5'b10000, 5'd0, 10'h0, 19'h0, 5'd2, 32'h0, 1, 5'd12);
        run_op("tlbsrch_miss", 5'b10000, 5'd0, 10'h0, 19'h0, 5'd2, 32'h0, 0, 5'd0);
    endtask

    task automatic test_invtlb();
        run_op("inv_op0", 5'b00001, 5'd0, 10'h3a5, 19'h7_0f0f, 5'd0, 32'h0, 1, 5'd3);
        run_op("inv_op5", 5'b00001, 5'd5, 10'h2c1, 19'h1_2345, 5'd0,
               (32'h1 << 3) | (32'h1 << 30), 0, 0);
        run_op("inv_op9", 5'b00001, 5'd9, 10'h011, 19'h0_00ff, 5'd0, 32'hffff_ffff, 0, 0);
    endtask

    task automatic test_fill_pointer();
        do_reset();
        repeat (40) @(posedge clk);
        #1;
        run_op("fill_first", 5'b01000, 5'd0, 10'h0, 19'h0, 5'd1, 32'h0, 0, 0);
        run_op("fill_second", 5'b01000, 5'd0, 10'h0, 19'h0, 5'd1, 32'h0, 0, 0);
    endtask

    task automatic test_misc_ops();
        run_op("tlbrd", 5'b00100, 5'd0, 10'h0, 19'h0, 5'd21, 32'h0, 1, 5'd4);
        run_op("no_op", 5'b00000, 5'd0, 10'h0, 19'h0, 5'd5, 32'h0, 1, 5'd4);
        run_op("prio_wr_fill", 5'b01010, 5'd0, 10'h0, 19'h0, 5'd13, 32'h0, 0, 0);
        run_op("prio_fill_rd", 5'b11100, 5'd0, 10'h0, 19'h0, 5'd13, 32'h0, 0, 0);
        run_op("prio_rd_srch", 5'b10100, 5'd0, 10'h0, 19'h0, 5'd30, 32'h0, 1, 5'd6);
    endtask

    task automatic test_back_to_back();
        logic [4:0] op;
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 7))
                0: op = 5'b00001;
                1: op = 5'b00010;
                2: op = 5'b00100;
                3: op = 5'b01000;
                4: op = 5'b10000;
                5: op = 5'b00000;
                default: op = 5'($urandom);
            endcase
            run_op("random", op, 5'($urandom_range(0, 8)), 10'($urandom), 19'($urandom),
                   5'($urandom), $urandom, 1'($urandom), 5'($urandom));
        end
    endtask

    task automatic test_reset_mid_scan();
        req_valid = 1; req_op = 5'b00001; req_inv_op = 5'd0;
        req_asid = 10'h1ff; req_vpn = 19'h5_5555; req_index = 0;
        @(posedge clk); #1;
        req_valid = 0;
        repeat (10) @(posedge clk);
        #1;
        n_cmp++;
        if (inv_check_en !== 1'b1 || inv_index !== 5'd10 || tlb_clr_en !== 1'b1) begin
            n_err++;
            $display("FAIL midscan_pos: got ice=%b idx=%0d clr=%b required 1/10/1",
                     inv_check_en, inv_index, tlb_clr_en);
        end
        #2 reset = 1'b1;
        #1;
        n_cmp++;
        if (obs !== idle_vec() || {inv_op, inv_asid, inv_vpn} !== 34'd0) begin
            n_err++;
            $display("FAIL midscan_reset: got %h args %h required %h args 0",
                     obs, {inv_op, inv_asid, inv_vpn}, idle_vec());
        end
        @(posedge clk); #1;
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            n_cmp++;
            if (obs !== idle_vec()) begin
                n_err++;
                $display("FAIL midscan_after%0d: got %h required %h", k, obs, idle_vec());
            end
        end
        run_op("wr_after_reset", 5'b00010, 5'd0, 10'h0, 19'h0, 5'd19, 32'h0, 0, 0);
    endtask

    initial begin
        reset = 1'b1;
        req_valid = 0; req_op = 0; req_inv_op = 0; req_asid = 0; req_vpn = 0; req_index = 0;
        srch_found = 0; srch_index = 0; inv_hit = 0;
        test_reset();
        test_tlbwr();
        test_tlbsrch();
        test_invtlb();
        test_fill_pointer();
        test_misc_ops();
        test_back_to_back();
        test_reset_mid_scan();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/tlb_op_seq.md
# tlb_op_seq

Sequencer that takes committed TLB maintenance instructions (tlbsrch, tlbrd, tlbwr, tlbfill, invtlb) from the write-back stage and drives the TLB array's single-cycle access ports. It accepts one request at a time and turns invtlb into a per-entry scan of the whole array. It supplies the tlbfill replacement index and holds the pipeline busy until the operation completes. It sits between the WB stage and the TLB / CSR TLB registers.

## Interface
- TLBNUM, 32, number of TLB entries (power of two)
- IDX_W, $clog2(TLBNUM), entry index width
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-high reset
- req_valid  in  1  WB presents a TLB op, already qualified by no-exception
- req_ready  out  1  sequencer can accept; high only in IDLE
- req_op  in  5  one-hot: [0] invtlb, [1] tlbwr, [2] tlbrd, [3] tlbfill, [4] tlbsrch
- req_inv_op  in  5  invtlb op code
- req_asid  in  10  invtlb ASID
- req_vpn  in  19  invtlb VPPN
- req_index  in  IDX_W  TLBIDX.index for tlbwr/tlbrd
- tlb_we  out  1  write strobe
- tlb_w_index  out  IDX_W  write index
- tlb_re  out  1  read strobe (tlbrd)
- tlb_s_en  out  1  search strobe (tlbsrch)
- tlb_r_index  out  IDX_W  read index
- srch_found  in  1  TLB search hit, valid 1 cycle after tlb_s_en
- srch_index  in  IDX_W  TLB search hit index, same timing as srch_found
- inv_check_en  out  1  scan compare strobe
- inv_index  out  IDX_W  entry under scan
- inv_op / inv_asid / inv_vpn  out  5/10/19  latched invtlb arguments
- inv_hit  in  1  combinational match of the entry at inv_index against the latched arguments
- tlb_clr_en  out  1  clear E bit of the entry at inv_index
- done_valid  out  1  one-cycle completion pulse
- resp_found  out  1  search result, valid with done_valid
- resp_index  out  IDX_W  search result index, valid with done_valid
- busy  out  1  state ≠ IDLE; OR'd into the pipeline stall

## Operation
- States: IDLE, ACCESS, SCAN, DONE.
- **IDLE**
  - req_ready=1.
  - When req_valid, latch the operands and the priority-resolved op: invtlb > tlbwr > tlbfill > tlbrd > tlbsrch.
  - invtlb → SCAN with scan index 0; any other op (including req_op=0) → ACCESS.
- **ACCESS** (1 cycle)
  - tlbwr: tlb_we=1, tlb_w_index=req_index.
  - tlbfill: tlb_we=1, tlb_w_index=latched fill pointer.
  - tlbrd: tlb_re=1, tlb_r_index=req_index.
  - tlbsrch: tlb_s_en=1.
  - req_op=0: no strobe.
  - → DONE.
- **SCAN**
  - Each cycle: inv_check_en=1, inv_index=scan index.
  - tlb_clr_en = inv_check_en & (inv_op ∈ {0,1} | (inv_op ∈ {2..6} & inv_hit)).
  - inv_op > 6: no clears, but the full scan still runs.
  - Index increments by 1. At TLBNUM-1 → DONE; the index does not wrap.
- **DONE** (1 cycle)
  - done_valid=1.
  - For tlbsrch, resp_found/resp_index take srch_found/srch_index sampled this cycle; other ops drive 0.
  - → IDLE.
- **Fill pointer**
  - Free-running IDX_W-bit counter, +1 every clock, wraps TLBNUM-1→0.
  - Its value in the acceptance cycle is latched as the tlbfill index.
- **Reset** (asynchronous, at any time, including mid-scan)
  - State=IDLE, fill pointer=0, scan index=0, latched operands=0.
  - All outputs 0 except req_ready=1.
  - No partial completion pulse is emitted.
- req_valid outside IDLE is ignored; WB must hold it until req_ready.

## Timing
- Acceptance at edge t (req_valid & req_ready).
- Single-access ops: strobe in cycle t+1, done_valid in t+2, req_ready high again in t+3.
- invtlb: inv_check_en in cycles t+1…t+TLBNUM, done_valid in t+TLBNUM+1, req_ready high again in t+TLBNUM+2.
- busy is high from t+1 through the done_valid cycle inclusive.
- All strobe outputs are decoded from registered state. tlb_clr_en additionally depends combinationally on inv_hit.

## Test plan
- tlbwr with req_index=7 accepted at t → tlb_we=1, tlb_w_index=7 only at t+1; done_valid only at t+2; busy at t+1..t+2.
- tlbsrch accepted at t, TLB returns srch_found=1, srch_index=12 at t+2 → done_valid at t+2 with resp_found=1, resp_index=12.
- invtlb inv_op=0 → 32 consecutive tlb_clr_en cycles, inv_index 0..31; done_valid at t+33.
- invtlb inv_op=5, inv_hit high only at indices 3 and 30 → tlb_clr_en exactly twice; inv_asid/inv_vpn stable over the whole scan.
- tlbfill accepted when the fill pointer is 40 mod 32 (40 edges after reset release) → tlb_w_index=8. A second fill accepted at the first ready cycle → index 11.
- Reset asserted mid-scan at inv_index=10 → all strobes drop immediately and no done_valid. After release: req_ready=1 and a new tlbwr completes normally.
